mult_div_unit: RTL

- Multicycle signed multiply/divide datapath serving the control unit's MULT and DIV states.
- The control unit pulses start together with the op select (mult_or_div; 1 = DIV, matching the control unit's MultOrDiv encoding), then waits for done or div0.
- The unit holds HI/LO result registers. MFHI/MFLO read them.
- div0 feeds the control unit's divide-by-zero exception path.

---
 rtl/mult_div_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit with HI/LO result registers.
// Magnitudes are processed unsigned for WIDTH cycles, then sign-corrected in a single FIX cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mult_or_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_RUN, S_DIV_RUN, S_FIX, S_DONE, S_DZ
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // MULT: {partial product, remaining multiplier bits}. DIV: low half shifts dividend out, quotient in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               sign_q, sign_d;
  logic               rsign_q, rsign_d;
  logic               is_div_q, is_div_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // -2^(W-1) maps onto its own bit pattern, which is the correct unsigned magnitude.
  assign abs_a = a_in[WIDTH-1] ? -a_in : a_in;
  assign abs_b = b_in[WIDTH-1] ? -b_in : b_in;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opb_q};

  assign prod_fix = sign_q  ? -acc_q : acc_q;
  assign quot_fix = sign_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rsign_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!mult_or_div) begin
            acc_d    = {{WIDTH{1'b0}}, abs_b};
            opb_d    = abs_a;
            sign_d   = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            rsign_d  = 1'b0;
            is_div_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_MUL_RUN;
          end else if (b_in == '0) begin
            state_d = S_DZ;
          end else begin
            acc_d    = {{WIDTH{1'b0}}, abs_a};
            rem_d    = '0;
            opb_d    = abs_b;
            sign_d   = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            rsign_d  = a_in[WIDTH-1];
            is_div_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_DIV_RUN;
          end
        end
      end
      S_MUL_RUN: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = S_FIX;
      end
      S_DIV_RUN: begin
        // Restoring step: keep the trial difference only when it did not borrow.
        if (div_trial[WIDTH]) begin
          rem_d = div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = div_trial[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_DZ:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    div0_d = (state_d == S_DZ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign div0   = div0_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
